// File: rtl/frame_queue_reader.sv
// Unpacks a 17-bit word queue (frame/row markers, pixels) into addressed RGB565 writes; BYTE_SWAP_EN swaps pixel bytes.
// Latency: read -> decode -> pix_valid, at most one pixel per 3 cycles; one FIFO read in flight.
// Backpressure: pix_valid/data/addr hold until pix_ready; no FIFO reads while a pixel is pending.
module frame_queue_reader #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic        MemClk,
  input  logic        RST,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [18:0] pix_addr,
  output logic        frame_start,
  output logic        frame_done,
  output logic        proto_err
);

  localparam int COL_W = $clog2(FRAME_WIDTH + 1);
  localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

  localparam logic [1:0] WAIT_FRAME = 2'd0;
  localparam logic [1:0] FETCH      = 2'd1;
  localparam logic [1:0] DECODE     = 2'd2;
  localparam logic [1:0] OUTPUT     = 2'd3;

  localparam logic [16:0]      FRAME_MARK = 17'h10000;
  localparam logic [16:0]      ROW_MARK   = 17'h10001;
  localparam logic [COL_W-1:0] COL_MAX    = COL_W'(FRAME_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL   = COL_W'(FRAME_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(FRAME_HEIGHT - 1);
  localparam logic [18:0]      ROW_STEP   = 19'(FRAME_WIDTH);

  logic [1:0]       state;
  logic             hunting;
  logic             frame_active;
  logic             row_open;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [18:0]      row_base;
  logic             vld_q;
  logic             last_q;
  logic             start_q;
  logic             err_q;
  logic [15:0]      data_q;
  logic [18:0]      addr_q;
  logic [15:0]      pix_word;
  logic             rd_fire;

`ifdef BYTE_SWAP_EN
  assign pix_word = {queue_data[7:0], queue_data[15:8]};
`else
  assign pix_word = queue_data[15:0];
`endif

  assign rd_fire = ~RST & ~queue_empty & ~vld_q & ((state == WAIT_FRAME) || (state == FETCH));

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign queue_rd_en = rd_fire;
  assign pix_valid   = ~RST & vld_q;
  assign pix_data    = RST ? 16'h0 : data_q;
  assign pix_addr    = RST ? 19'h0 : addr_q;
  assign frame_start = ~RST & start_q;
  assign proto_err   = ~RST & err_q;
  assign frame_done  = ~RST & vld_q & pix_ready & last_q;

  always_ff @(posedge MemClk) begin
    if (RST) begin
      state        <= WAIT_FRAME;
      hunting      <= 1'b1;
      frame_active <= 1'b0;
      row_open     <= 1'b0;
      row          <= '0;
      col          <= '0;
      row_base     <= '0;
      vld_q        <= 1'b0;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        WAIT_FRAME, FETCH: begin
          if (rd_fire) begin
            hunting <= (state == WAIT_FRAME);
            state   <= DECODE;
          end
        end
        DECODE: begin
          state <= FETCH;
          if (queue_data == FRAME_MARK) begin
            start_q      <= 1'b1;
            err_q        <= frame_active;
            frame_active <= 1'b1;
            row_open     <= 1'b0;
            row          <= '0;
            col          <= '0;
            row_base     <= '0;
          end else if (hunting) begin
            state <= WAIT_FRAME;
          end else if (queue_data == ROW_MARK) begin
            if (!row_open) begin
              row_open <= 1'b1;
              row      <= '0;
              row_base <= '0;
              col      <= '0;
            end else if (row == LAST_ROW) begin
              err_q        <= 1'b1;
              frame_active <= 1'b0;
              row_open     <= 1'b0;
              state        <= WAIT_FRAME;
            end else begin
              row      <= row + ROW_W'(1);
              row_base <= row_base + ROW_STEP;
              col      <= '0;
            end
          end else if (!queue_data[16]) begin
            if (row_open && (col != COL_MAX)) begin
              vld_q  <= 1'b1;
              data_q <= pix_word;
              addr_q <= row_base + 19'(col);
              last_q <= (row == LAST_ROW) && (col == LAST_COL);
              state  <= OUTPUT;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            err_q <= 1'b1;
          end
        end
        OUTPUT: begin
          if (pix_ready) begin
            vld_q <= 1'b0;
            col   <= col + COL_W'(1);
            if (last_q) begin
              frame_active <= 1'b0;
              row_open     <= 1'b0;
              state        <= WAIT_FRAME;
            end else begin
              state <= FETCH;
            end
          end
        end
        default: state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_queue_reader.sv
// Randomized and directed bench for frame_queue_reader (4x2 frame) against a word-level reference model.
module tb_frame_queue_reader;
  localparam int W = 4;
  localparam int H = 2;
  localparam logic [16:0] FM = 17'h10000;
  localparam logic [16:0] RM = 17'h10001;

  logic        MemClk = 1'b0;
  logic        RST = 1'b1;
  logic        queue_empty = 1'b1;
  logic [16:0] queue_data = '0;
  logic        queue_rd_en;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [15:0] pix_data;
  logic [18:0] pix_addr;
  logic        frame_start;
  logic        frame_done;
  logic        proto_err;

  always #5 MemClk = ~MemClk;

  frame_queue_reader #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .MemClk(MemClk), .RST(RST), .queue_empty(queue_empty), .queue_data(queue_data),
    .queue_rd_en(queue_rd_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_addr(pix_addr), .frame_start(frame_start),
    .frame_done(frame_done), .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [16:0] fifo_q[$];
  bit          stall_en = 1'b0;
  int          rdy_mode = 0;
  int          hold_left = 0;

  // Reference model state: word-level rules of the protocol
  bit m_hunt = 1'b1, m_active = 1'b0, m_open = 1'b0;
  int m_row = 0, m_col = 0;
  int m_fs = 0, m_err = 0, m_fd = 0, m_both = 0, m_pix = 0;
  int o_fs = 0, o_err = 0, o_fd = 0, o_both = 0, o_pix = 0, o_held = 0;

  function automatic logic [15:0] pix_of(input logic [16:0] w);
`ifdef BYTE_SWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w[15:0];
`endif
  endfunction

  task automatic model_word(input logic [16:0] w);
    exp_t e;
    if (w == FM) begin
      m_fs++;
      if (m_active) begin m_err++; m_both++; end
      m_active = 1'b1; m_open = 1'b0; m_row = 0; m_col = 0; m_hunt = 1'b0;
    end else if (m_hunt) begin
      // discarded silently while waiting for a frame
    end else if (w == RM) begin
      if (!m_open) begin m_open = 1'b1; m_row = 0; m_col = 0; end
      else if (m_row == H - 1) begin m_err++; m_hunt = 1'b1; m_active = 1'b0; m_open = 1'b0; end
      else begin m_row++; m_col = 0; end
    end else if (!w[16]) begin
      if (m_open && m_col < W) begin
        e.addr = 19'(m_row * W + m_col);
        e.data = pix_of(w);
        e.last = (m_row == H - 1) && (m_col == W - 1);
        exp_q.push_back(e);
        m_pix++;
        m_col++;
        if (e.last) begin m_fd++; m_hunt = 1'b1; m_active = 1'b0; m_open = 1'b0; end
      end else begin
        m_err++;
      end
    end else begin
      m_err++;
    end
  endtask

  task automatic send(input logic [16:0] w);
    model_word(w);
    fifo_q.push_back(w);
  endtask

  task automatic clear_all();
    fifo_q.delete(); exp_q.delete();
    queue_empty = 1'b1;
    m_hunt = 1'b1; m_active = 1'b0; m_open = 1'b0; m_row = 0; m_col = 0;
    m_fs = 0; m_err = 0; m_fd = 0; m_both = 0; m_pix = 0;
    o_fs = 0; o_err = 0; o_fd = 0; o_both = 0; o_pix = 0; o_held = 0;
  endtask

  task automatic apply_reset();
    @(posedge MemClk); #2;
    RST = 1'b1;
    @(posedge MemClk); #2;
    clear_all();
    RST = 1'b0;
  endtask

  task automatic check_outputs_low(input string tag);
    check_eq({tag, "_rd"},  32'(queue_rd_en), 0);
    check_eq({tag, "_vld"}, 32'(pix_valid), 0);
    check_eq({tag, "_dat"}, 32'(pix_data), 0);
    check_eq({tag, "_adr"}, 32'(pix_addr), 0);
    check_eq({tag, "_fs"},  32'(frame_start), 0);
    check_eq({tag, "_fd"},  32'(frame_done), 0);
    check_eq({tag, "_err"}, 32'(proto_err), 0);
  endtask

  task automatic drain(input string tag);
    int idle = 0;
    int cyc = 0;
    while (idle < 8 && cyc < 3000) begin
      @(negedge MemClk);
      cyc++;
      if (fifo_q.size() == 0 && !pix_valid) idle++; else idle = 0;
    end
    check_eq({tag, "_drain"}, 32'(idle >= 8), 1);
    check_eq({tag, "_pix"},  32'(o_pix), 32'(m_pix));
    check_eq({tag, "_left"}, 32'(exp_q.size()), 0);
    check_eq({tag, "_fs"},   32'(o_fs), 32'(m_fs));
    check_eq({tag, "_err"},  32'(o_err), 32'(m_err));
    check_eq({tag, "_fd"},   32'(o_fd), 32'(m_fd));
    check_eq({tag, "_both"}, 32'(o_both), 32'(m_both));
  endtask

  // FIFO model: word appears on queue_data the cycle after the read strobe
  always @(posedge MemClk) begin
    if (queue_rd_en && fifo_q.size() > 0) queue_data <= fifo_q.pop_front();
    #1;
    queue_empty = (fifo_q.size() == 0) || (stall_en && $urandom_range(0, 3) == 0);
  end

  always @(posedge MemClk) begin
    #1;
    case (rdy_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ($urandom_range(0, 2) != 0);
      2: if (pix_valid && hold_left > 0) begin pix_ready = 1'b0; hold_left--; end
         else pix_ready = 1'b1;
      default: pix_ready = 1'b0;
    endcase
  end

  bit          prev_hold = 1'b0;
  logic [15:0] h_data;
  logic [18:0] h_addr;

  always @(negedge MemClk) begin
    if (RST) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_vld", 32'(pix_valid), 1);
        check_eq("hold_dat", 32'(pix_data), 32'(h_data));
        check_eq("hold_adr", 32'(pix_addr), 32'(h_addr));
      end
      if (pix_valid) check_eq("rd_excl", 32'(queue_rd_en), 0);
      if (pix_valid && pix_ready) begin
        o_pix++;
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("pix_adr", 32'(pix_addr), 32'(e.addr));
          check_eq("pix_dat", 32'(pix_data), 32'(e.data));
          check_eq("pix_done", 32'(frame_done), 32'(e.last));
        end
      end
      if (pix_valid && !pix_ready) o_held++;
      if (frame_start) o_fs++;
      if (proto_err) o_err++;
      if (frame_done) o_fd++;
      if (frame_start && proto_err) o_both++;
      prev_hold = pix_valid && !pix_ready;
      h_data = pix_data;
      h_addr = pix_addr;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [16:0] w;
    logic [16:0] words[$];

    // A word waits in the FIFO during reset; no read may be issued
    fifo_q.push_back(FM);
    repeat (3) @(posedge MemClk);
    @(negedge MemClk);
    check_outputs_low("rst");
    @(posedge MemClk); #2;
    clear_all();
    RST = 1'b0;

    // Full 4x2 frame with pix_ready held high
    send(FM); send(RM);
    for (int i = 0; i < W; i++) send(17'(16'h0AAA + i));
    send(RM);
    for (int i = 0; i < W; i++) send(17'(16'h0BB0 + i));
    drain("full");

    // Sink stalls 10 cycles on the first pixel
    apply_reset();
    rdy_mode = 2; hold_left = 10;
    send(FM); send(RM); send(17'h01234);
    drain("stall");
    check_eq("stall_held", 32'(o_held), 10);
    rdy_mode = 0;

    // Five pixels in a 4-wide row
    apply_reset();
    send(FM); send(RM);
    for (int i = 0; i < 5; i++) send(17'(16'h0C00 + i));
    drain("over");

    // Pixels before any frame marker
    apply_reset();
    send(17'h00001); send(17'h00002);
    drain("pre");

    // Frame marker after three pixels restarts the frame
    apply_reset();
    send(FM); send(RM);
    for (int i = 0; i < 3; i++) send(17'(16'h0D00 + i));
    send(FM); send(RM);
    for (int i = 0; i < W; i++) send(17'(16'h0E00 + i));
    send(RM);
    for (int i = 0; i < W; i++) send(17'(16'h0F00 + i));
    drain("restart");

    // Reset while a pixel request is pending
    apply_reset();
    rdy_mode = 3;
    send(FM); send(RM); send(17'h05555);
    cyc = 0;
    while (!pix_valid && cyc < 100) begin @(negedge MemClk); cyc++; end
    check_eq("mid_vld_seen", 32'(pix_valid), 1);
    @(posedge MemClk); #2;
    RST = 1'b1;
    @(negedge MemClk);
    check_outputs_low("mid_in");
    @(posedge MemClk); #2;
    clear_all();
    RST = 1'b0;
    @(negedge MemClk);
    check_eq("mid_out_vld", 32'(pix_valid), 0);
    rdy_mode = 0;
    send(FM); send(RM);
    for (int i = 0; i < W; i++) send(17'(16'h0A50 + i));
    send(RM);
    for (int i = 0; i < W; i++) send(17'(16'h0A60 + i));
    drain("mid_new");

    // Random frames with occasional corrupted words, random stalls and backpressure
    rdy_mode = 1; stall_en = 1'b1;
    for (int r = 0; r < 10; r++) begin
      words.delete();
      words.push_back(FM);
      for (int y = 0; y < H; y++) begin
        words.push_back(RM);
        for (int x = 0; x < W; x++) words.push_back({1'b0, 16'($urandom)});
      end
      foreach (words[k]) begin
        w = words[k];
        if ($urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: w = FM;
            1: w = RM;
            2: w = {1'b0, 16'($urandom)};
            default: w = {1'b1, 16'($urandom_range(2, 16'hFFFF))};
          endcase
        end
        send(w);
      end
      drain("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_queue_reader.md
FRAME_QUEUE_READER -- requirements
Module: frame_queue_reader

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 640, pixels per row.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 480, rows per frame.
REQ-003 SHALL have port MemClk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port queue_empty  input  1  FIFO empty flag.
REQ-006 SHALL have port queue_data  input  17  FIFO read word; bit16=1 control, bit16=0 pixel {second byte, first byte}.
REQ-007 SHALL have port queue_rd_en  output  1  FIFO read strobe; data valid the cycle after.
REQ-008 SHALL have port pix_valid  output  1  pixel write request.
REQ-009 SHALL have port pix_ready  input  1  sink accepts the request when high with pix_valid.
REQ-010 SHALL have port pix_data  output  16  RGB565 pixel.
REQ-011 SHALL have port pix_addr  output  19  linear address row*FRAME_WIDTH+col.
REQ-012 SHALL have port frame_start  output  1  one-cycle pulse on a decoded frame marker.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the last pixel is accepted.
REQ-014 SHALL have port proto_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-015 SHALL decode 0x10000 as the frame marker, 0x10001 as the row marker, and any bit16=0 word as a pixel.
REQ-016 SHALL use states WAIT_FRAME, FETCH, DECODE, OUTPUT; reset enters WAIT_FRAME.
REQ-017 SHALL keep at most one FIFO read in flight, and SHALL assert queue_rd_en for one cycle only in FETCH or WAIT_FRAME with queue_empty=0 and pix_valid=0.
REQ-018 SHALL decode the returned word the cycle after queue_rd_en (DECODE) and SHALL assert pix_valid on the next cycle; peak throughput is one pixel per 3 cycles.
REQ-019 SHALL hold pix_valid, pix_data and pix_addr stable until pix_ready=1, and SHALL NOT make pix_valid depend combinationally on pix_ready.
REQ-020 In WAIT_FRAME, SHALL discard all words other than the frame marker, with no error pulse.
REQ-021 On the frame marker, SHALL pulse frame_start and clear the row, column and row-base counters.
REQ-022 On the frame marker, SHALL set the next row marker to open row 0.
REQ-023 On a frame marker while a frame is incomplete, SHALL also pulse proto_err, then restart the frame.
REQ-024 On a row marker, SHALL open the next row (row_base += FRAME_WIDTH, except for the first row) and clear the column.
REQ-025 On a row marker that would open row FRAME_HEIGHT, SHALL pulse proto_err and return to WAIT_FRAME.
REQ-026 On a pixel with an open row and col<FRAME_WIDTH, SHALL output pix_addr=row_base+col, then increment col on acceptance.
REQ-027 On a pixel before any row marker, or with col=FRAME_WIDTH, SHALL drop the pixel and pulse proto_err.
REQ-028 On any other control word, SHALL ignore the word and pulse proto_err.
REQ-029 SHALL compute addresses with an adder only, not a multiplier.
REQ-030 On acceptance of row FRAME_HEIGHT-1, col FRAME_WIDTH-1, SHALL pulse frame_done in the same cycle as the handshake and return to WAIT_FRAME.
REQ-031 SHALL treat queue_empty=1 in FETCH as a stall, with no read and no state change.

Reset
REQ-032 While RST=1, SHALL drive queue_rd_en, pix_valid, frame_start, frame_done, proto_err, pix_data and pix_addr to 0.
REQ-033 While RST=1, SHALL clear all counters and enter WAIT_FRAME.
REQ-034 On reset mid-operation, SHALL discard any in-flight FIFO word and any pending pixel request without handshake.

Configuration
REQ-035 With macro BYTE_SWAP_EN defined, SHALL output pix_data={queue_data[7:0],queue_data[15:8]}.
REQ-036 With BYTE_SWAP_EN undefined, SHALL output pix_data=queue_data[15:0]; all other behaviour is identical.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=2)
REQ-037 Words 0x10000, 0x10001, 4 pixels 0x0AAA..0x0AAD, 0x10001, 4 pixels, with pix_ready=1 -> addr 0..7 in order, one frame_start, one frame_done on addr 7.
REQ-038 pix_ready held 0 for 10 cycles on pixel 0x1234 -> pix_valid/data/addr stable, queue_rd_en=0 throughout; accepted on release.
REQ-039 Five pixels after one row marker -> addr 0..3 written, 5th dropped, proto_err pulses once.
REQ-040 Pixels 0x0001, 0x0002 before any frame marker -> no pix_valid, no proto_err.
REQ-041 Frame marker after 3 pixels of row 0 -> proto_err and frame_start in the same cycle, next row 0 restarts at addr 0.
REQ-042 RST pulsed while pix_valid=1 -> all outputs 0 the next cycle; a new frame decodes from addr 0.
